hazard_scoreboard_unit: RTL and testbench

//   Hazard unit for the 5-stage pipeline, extended with a scoreboard for one multi-cycle (MD) unit.
//   - Resolves data and control hazards: E/D forwarding, load-use stall, branch stall, jump flush.
//   - Tracks the single outstanding multi-cycle op (MUL/DIV) of MD_LAT cycles and stalls D on
//     RAW, WAW and structural hazards against it. Sits beside the pipeline registers;

---
 rtl/hazard_scoreboard_unit.sv | 213 +++++++++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Hazard unit for a 5-stage pipeline with a scoreboard for one outstanding
//   multi-cycle (MUL/DIV) operation. Produces stall/flush enables for the
//   pipeline registers and select lines for the E and D forwarding muxes.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), synchronous active-high reset
//   BranchD_i, JumpD_i, MdOpD_i  D-stage instruction class
//   RsD_i, RtD_i, WriteRegD_i    D-stage source / destination registers
//   RsE_i, RtE_i, WriteRegE_i    E-stage sources / destination
//   RegWriteE_i, MemtoRegE_i     E-stage write controls
//   MdStartE_i                   MD op issuing from E this cycle
//   WriteRegM_i, RegWriteM_i, MemtoRegM_i   M-stage destination and controls
//   WriteRegW_i, RegWriteW_i     W-stage destination and write enable
//   StallF_o, StallD_o, FlushE_o pipeline register controls
//   ForwardAE_o, ForwardBE_o     E operand select: 00 regfile, 01 W, 10 M
//   ForwardAD_o, ForwardBD_o     D branch operand select from M ALU result
//   MdBusy_o, MdDone_o           MD scoreboard status
//   MdWriteReg_o                 destination of the outstanding MD op
//   StallCnt_o, FlushCnt_o       saturating perf counters (HAZARD_PERF_CNT_EN only)
//
// Build option: define HAZARD_PERF_CNT_EN to add the StallCnt_o / FlushCnt_o counters.

module hazard_scoreboard_unit #(
  parameter int unsigned RA_W   = 5,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            BranchD_i,
  input  logic            JumpD_i,
  input  logic            MdOpD_i,
  input  logic [RA_W-1:0] RsD_i,
  input  logic [RA_W-1:0] RtD_i,
  input  logic [RA_W-1:0] WriteRegD_i,
  input  logic [RA_W-1:0] RsE_i,
  input  logic [RA_W-1:0] RtE_i,
  input  logic [RA_W-1:0] WriteRegE_i,
  input  logic            RegWriteE_i,
  input  logic            MemtoRegE_i,
  input  logic            MdStartE_i,
  input  logic [RA_W-1:0] WriteRegM_i,
  input  logic            RegWriteM_i,
  input  logic            MemtoRegM_i,
  input  logic [RA_W-1:0] WriteRegW_i,
  input  logic            RegWriteW_i,
  output logic            StallF_o,
  output logic            StallD_o,
  output logic            FlushE_o,
  output logic [1:0]      ForwardAE_o,
  output logic [1:0]      ForwardBE_o,
  output logic            ForwardAD_o,
  output logic            ForwardBD_o,
  output logic            MdBusy_o,
  output logic            MdDone_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]     StallCnt_o,
  output logic [31:0]     FlushCnt_o,
`endif
  output logic [RA_W-1:0] MdWriteReg_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RA_W-1:0] md_reg_q, md_reg_d;

  logic lwstall, brstall, mdstall, stall;
  logic md_active, md_busy;

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_e(input logic [RA_W-1:0] src,
                                       input logic [RA_W-1:0] wr_m, input logic we_m,
                                       input logic [RA_W-1:0] wr_w, input logic we_w);
    if (src != '0 && src == wr_m && we_m) begin
      return 2'b10;
    end else if (src != '0 && src == wr_w && we_w) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    ForwardAE_o = fwd_e(RsE_i, WriteRegM_i, RegWriteM_i, WriteRegW_i, RegWriteW_i);
    ForwardBE_o = fwd_e(RtE_i, WriteRegM_i, RegWriteM_i, WriteRegW_i, RegWriteW_i);
    // A load in M has no ALU result to forward; brstall covers that case.
    ForwardAD_o = (RsD_i != '0) && (RsD_i == WriteRegM_i) && RegWriteM_i && !MemtoRegM_i;
    ForwardBD_o = (RtD_i != '0) && (RtD_i == WriteRegM_i) && RegWriteM_i && !MemtoRegM_i;
  end

  // ---------------------------------------------------------------------------
  // Stall conditions
  // ---------------------------------------------------------------------------
  assign md_active = (state_q != StIdle);
  assign md_busy   = (state_q == StBusy);

  always_comb begin
    lwstall = MemtoRegE_i && (WriteRegE_i != '0) &&
              ((RsD_i == WriteRegE_i) || (RtD_i == WriteRegE_i));

    brstall = BranchD_i &&
              ((RegWriteE_i && (WriteRegE_i != '0) &&
                ((WriteRegE_i == RsD_i) || (WriteRegE_i == RtD_i))) ||
               (MemtoRegM_i && (WriteRegM_i != '0) &&
                ((WriteRegM_i == RsD_i) || (WriteRegM_i == RtD_i))));

    // RAW holds through DONE: the result is only in the regfile after that cycle.
    mdstall = (md_active && (md_reg_q != '0) &&
               ((RsD_i == md_reg_q) || (RtD_i == md_reg_q))) ||
              (md_busy && (md_reg_q != '0) && (WriteRegD_i == md_reg_q)) ||
              (md_busy && MdOpD_i) ||
              (MdStartE_i && MdOpD_i);

    stall = lwstall | brstall | mdstall;
  end

  assign StallF_o = stall;
  assign StallD_o = stall;
  assign FlushE_o = stall | JumpD_i;

  // ---------------------------------------------------------------------------
  // MD scoreboard FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_reg_d = md_reg_q;
    case (state_q)
      StIdle: begin
        if (MdStartE_i) begin
          state_d  = StBusy;
          cnt_d    = CNT_W'(MD_LAT - 1);
          md_reg_d = WriteRegE_i;
        end
      end
      StBusy: begin
        // A second issue while busy is illegal and deliberately ignored.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (MdStartE_i) begin
          state_d  = StBusy;
          cnt_d    = CNT_W'(MD_LAT - 1);
          md_reg_d = WriteRegE_i;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      md_reg_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      md_reg_q <= md_reg_d;
    end
  end

  assign MdBusy_o     = md_active;
  assign MdDone_o     = (state_q == StDone);
  assign MdWriteReg_o = md_reg_q;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (FlushE_o && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Testbench for hazard_scoreboard_unit: directed pipeline scenarios followed by
// random stimulus. Each cycle's expected outputs come from a reference model
// and are queued; a monitor on the falling edge pops and compares.

module tb_hazard_scoreboard_unit;

  localparam int unsigned RA_W   = 5;
  localparam int unsigned MD_LAT = 4;
  localparam int unsigned CNT_W  = 3;

  logic clk_i = 1'b0;
  logic rst_i;
  logic BranchD_i, JumpD_i, MdOpD_i;
  logic [RA_W-1:0] RsD_i, RtD_i, WriteRegD_i, RsE_i, RtE_i, WriteRegE_i;
  logic RegWriteE_i, MemtoRegE_i, MdStartE_i;
  logic [RA_W-1:0] WriteRegM_i, WriteRegW_i;
  logic RegWriteM_i, MemtoRegM_i, RegWriteW_i;
  logic StallF_o, StallD_o, FlushE_o, ForwardAD_o, ForwardBD_o, MdBusy_o, MdDone_o;
  logic [1:0] ForwardAE_o, ForwardBE_o;
  logic [RA_W-1:0] MdWriteReg_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt_o, FlushCnt_o;
`endif

  always #5 clk_i = ~clk_i;

  hazard_scoreboard_unit #(.RA_W(RA_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .BranchD_i(BranchD_i), .JumpD_i(JumpD_i), .MdOpD_i(MdOpD_i),
    .RsD_i(RsD_i), .RtD_i(RtD_i), .WriteRegD_i(WriteRegD_i),
    .RsE_i(RsE_i), .RtE_i(RtE_i), .WriteRegE_i(WriteRegE_i),
    .RegWriteE_i(RegWriteE_i), .MemtoRegE_i(MemtoRegE_i), .MdStartE_i(MdStartE_i),
    .WriteRegM_i(WriteRegM_i), .RegWriteM_i(RegWriteM_i), .MemtoRegM_i(MemtoRegM_i),
    .WriteRegW_i(WriteRegW_i), .RegWriteW_i(RegWriteW_i),
    .StallF_o(StallF_o), .StallD_o(StallD_o), .FlushE_o(FlushE_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
    .ForwardAD_o(ForwardAD_o), .ForwardBD_o(ForwardBD_o),
    .MdBusy_o(MdBusy_o), .MdDone_o(MdDone_o),
`ifdef HAZARD_PERF_CNT_EN
    .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o),
`endif
    .MdWriteReg_o(MdWriteReg_o)
  );

  typedef struct {
    logic       stall;
    logic       flush;
    logic [1:0] fae;
    logic [1:0] fbe;
    logic       fad;
    logic       fbd;
    logic       busy;
    logic       done;
    int         mdreg;
    int unsigned scnt;
    int unsigned fcnt;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: cycles elapsed since the outstanding MD op issued (0 = none).
  int          md_age = 0;
  int          md_reg = 0;
  int unsigned m_scnt = 0;
  int unsigned m_fcnt = 0;

  function automatic logic [1:0] ref_fwd(int src, int wm, bit wem, int ww, bit wew);
    if (src != 0 && src == wm && wem) return 2'b10;
    if (src != 0 && src == ww && wew) return 2'b01;
    return 2'b00;
  endfunction

  // Computes this cycle's expected outputs from the current inputs, then
  // advances the model across the coming clock edge.
  task automatic apply();
    exp_t e;
    bit lw, br, md, in_busy, active, done;
    int rsd = int'(RsD_i), rtd = int'(RtD_i), wrd = int'(WriteRegD_i);
    int wre = int'(WriteRegE_i), wrm = int'(WriteRegM_i), wrw = int'(WriteRegW_i);

    active  = (md_age != 0);
    done    = (md_age == MD_LAT);
    in_busy = active && !done;

    lw = MemtoRegE_i && wre != 0 && (rsd == wre || rtd == wre);
    br = BranchD_i && ((RegWriteE_i && wre != 0 && (wre == rsd || wre == rtd)) ||
                       (MemtoRegM_i && wrm != 0 && (wrm == rsd || wrm == rtd)));
    md = (active && md_reg != 0 && (rsd == md_reg || rtd == md_reg)) ||
         (in_busy && md_reg != 0 && wrd == md_reg) ||
         (in_busy && MdOpD_i) || (MdStartE_i && MdOpD_i);

    e.stall = lw | br | md;
    e.flush = e.stall | JumpD_i;
    e.fae   = ref_fwd(int'(RsE_i), wrm, RegWriteM_i, wrw, RegWriteW_i);
    e.fbe   = ref_fwd(int'(RtE_i), wrm, RegWriteM_i, wrw, RegWriteW_i);
    e.fad   = rsd != 0 && rsd == wrm && RegWriteM_i && !MemtoRegM_i;
    e.fbd   = rtd != 0 && rtd == wrm && RegWriteM_i && !MemtoRegM_i;
    e.busy  = active;
    e.done  = done;
    e.mdreg = md_reg;
    e.scnt  = m_scnt;
    e.fcnt  = m_fcnt;
    exp_q.push_back(e);

    if (rst_i) begin
      md_age = 0;
      md_reg = 0;
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      if (e.stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
      if (e.flush && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
      if (MdStartE_i && (!active || done)) begin
        md_age = 1;
        md_reg = wre;
      end else if (done) begin
        md_age = 0;
      end else if (active) begin
        md_age++;
      end
    end
  endtask

  task automatic clear_inputs();
    rst_i = 1'b0;
    {BranchD_i, JumpD_i, MdOpD_i, RegWriteE_i, MemtoRegE_i, MdStartE_i} = '0;
    {RegWriteM_i, MemtoRegM_i, RegWriteW_i} = '0;
    {RsD_i, RtD_i, WriteRegD_i, RsE_i, RtE_i, WriteRegE_i, WriteRegM_i, WriteRegW_i} = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
    clear_inputs();
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("StallF", 32'(StallF_o), 32'(e.stall));
      chk("StallD", 32'(StallD_o), 32'(e.stall));
      chk("FlushE", 32'(FlushE_o), 32'(e.flush));
      chk("ForwardAE", 32'(ForwardAE_o), 32'(e.fae));
      chk("ForwardBE", 32'(ForwardBE_o), 32'(e.fbe));
      chk("ForwardAD", 32'(ForwardAD_o), 32'(e.fad));
      chk("ForwardBD", 32'(ForwardBD_o), 32'(e.fbd));
      chk("MdBusy", 32'(MdBusy_o), 32'(e.busy));
      chk("MdDone", 32'(MdDone_o), 32'(e.done));
      chk("MdWriteReg", 32'(MdWriteReg_o), 32'(e.mdreg));
`ifdef HAZARD_PERF_CNT_EN
      chk("StallCnt", StallCnt_o, e.scnt);
      chk("FlushCnt", FlushCnt_o, e.fcnt);
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    clear_inputs();
    apply();                         // reset state: all outputs 0

    // lw r2 in E, add r3,r2,r4 in D: one stall, then W forward.
    next_cycle(); MemtoRegE_i = 1; RegWriteE_i = 1; WriteRegE_i = 2; RsD_i = 2; RtD_i = 4;
    apply();
    next_cycle(); RegWriteW_i = 1; WriteRegW_i = 2; RsE_i = 2; RtE_i = 4; apply();

    // M and W both write r5: M wins. RsE=0 with WriteRegM=0: no forward.
    next_cycle(); RegWriteM_i = 1; WriteRegM_i = 5; RegWriteW_i = 1; WriteRegW_i = 5;
    RsE_i = 5; apply();
    next_cycle(); RegWriteM_i = 1; WriteRegM_i = 0; RsE_i = 0; RtE_i = 0; apply();

    // beq r6: E ALU writes r6, then M forward, then M load -> stall.
    next_cycle(); BranchD_i = 1; RsD_i = 6; RtD_i = 1; RegWriteE_i = 1; WriteRegE_i = 6;
    apply();
    next_cycle(); BranchD_i = 1; RsD_i = 6; RtD_i = 1; RegWriteM_i = 1; WriteRegM_i = 6;
    apply();
    next_cycle(); BranchD_i = 1; RsD_i = 6; RtD_i = 1; RegWriteM_i = 1; MemtoRegM_i = 1;
    WriteRegM_i = 6; apply();
    next_cycle(); JumpD_i = 1; apply();

    // MD op to r7, dependent add in D stalls through DONE.
    next_cycle(); MdStartE_i = 1; WriteRegE_i = 7; RsD_i = 8; apply();
    for (int i = 0; i < 6; i++) begin
      next_cycle(); RsD_i = 7; RtD_i = 1; WriteRegD_i = 8; apply();
    end

    // MD op to r9, mul in D stalls structurally; back-to-back issue in DONE.
    next_cycle(); MdStartE_i = 1; WriteRegE_i = 9; apply();
    for (int i = 0; i < 3; i++) begin
      next_cycle(); MdOpD_i = 1; WriteRegD_i = 10; apply();
    end
    next_cycle(); MdStartE_i = 1; WriteRegE_i = 10; apply();   // DONE + new issue
    next_cycle(); MdStartE_i = 1; WriteRegE_i = 11; apply();   // ignored while busy
    next_cycle(); WriteRegD_i = 10; apply();                   // WAW
    next_cycle(); rst_i = 1; RsD_i = 10; apply();              // reset mid-op
    for (int i = 0; i < 5; i++) begin
      next_cycle(); RsD_i = 10; apply();
    end

    // Random traffic over a small register range to make collisions common.
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      rst_i       = ($urandom_range(0, 79) == 0);
      BranchD_i   = 1'($urandom_range(0, 1));
      JumpD_i     = ($urandom_range(0, 7) == 0);
      MdOpD_i     = ($urandom_range(0, 3) == 0);
      MdStartE_i  = ($urandom_range(0, 3) == 0);
      RegWriteE_i = 1'($urandom_range(0, 1));
      MemtoRegE_i = 1'($urandom_range(0, 1));
      RegWriteM_i = 1'($urandom_range(0, 1));
      MemtoRegM_i = 1'($urandom_range(0, 1));
      RegWriteW_i = 1'($urandom_range(0, 1));
      RsD_i       = RA_W'($urandom_range(0, 3));
      RtD_i       = RA_W'($urandom_range(0, 3));
      WriteRegD_i = RA_W'($urandom_range(0, 3));
      RsE_i       = RA_W'($urandom_range(0, 3));
      RtE_i       = RA_W'($urandom_range(0, 3));
      WriteRegE_i = RA_W'($urandom_range(0, 3));
      WriteRegM_i = RA_W'($urandom_range(0, 3));
      WriteRegW_i = RA_W'($urandom_range(0, 3));
      apply();
    end

    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
